// File: rtl/rag_csd_sched_pkg.sv
// Shared types and defaults for the normalizer scheduler.
package rag_csd_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after rr_ptr,
// scanning upward and wrapping. Produces a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] scan_idx;

    // Walk the requesters in priority order starting from rr_ptr; keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_vld && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/normalizer_scheduler.sv
// Time-shares one embedding normalizer among NUM_REQ requesters: round-robin
// grant, one start pulse per operation, rising-edge completion detect, tagged
// response, and a completion timeout that latches a sticky hang flag.
module normalizer_scheduler
    import rag_csd_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [IDX_W-1:0]              norm_sel,
    output logic                          norm_start,
    input  logic                          norm_done,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [TAG_W-1:0]              resp_tag,
    output logic                          resp_err,
    output logic                          busy,
    output logic                          norm_hung
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             hung_q;
    logic             done_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic               arb_en;
    logic               take;
    logic               done_rise;
    logic               timeout;
    logic               resp_hs;

    // Arbitration only happens in IDLE and never once the normalizer is declared hung.
    assign arb_en    = (state_q == S_IDLE) && !hung_q;
    assign take      = arb_en && arb_vld;
    // Edge detect: a done level left high by the previous operation must not complete this one.
    assign done_rise = norm_done & ~done_q;
    assign timeout   = (wait_cnt_q == CNT_LAST);
    assign resp_hs   = resp_ready[idx_q];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid & {NUM_REQ{arb_en}}),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        norm_start = 1'b0;
        resp_valid = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = arb_grant;
                if (take) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                norm_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise || timeout) state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid[idx_q] = 1'b1;
                if (resp_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request context, wait counter, completion status and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            hung_q     <= 1'b0;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            done_q <= norm_done;
            unique case (state_q)
                S_IDLE: begin
                    if (take) begin
                        idx_q <= arb_idx;
                        tag_q <= req_tag[arb_idx];
                        err_q <= 1'b0;
                    end
                end
                S_ISSUE: wait_cnt_q <= '0;
                S_WAIT: begin
                    // A completion edge on the last allowed cycle still counts as success.
                    if (done_rise) begin
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        err_q  <= 1'b1;
                        hung_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_hs) rr_ptr_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign norm_sel  = idx_q;
    assign resp_tag  = tag_q;
    assign resp_err  = err_q;
    assign busy      = (state_q != S_IDLE);
    assign norm_hung = hung_q;

endmodule

// File: tb/tb_normalizer_scheduler.sv
// Directed + randomized bench for normalizer_scheduler with an abstract
// round-robin/hang model; the bench also plays the normalizer's done level.
module tb_normalizer_scheduler;

    localparam int NR = 4;
    localparam int TW = 8;
    localparam int TO = 64;
    localparam int IW = $clog2(NR);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][TW-1:0] req_tag;
    logic [NR-1:0]        req_ready;
    logic [IW-1:0]        norm_sel;
    logic                 norm_start;
    logic                 norm_done;
    logic [NR-1:0]        resp_valid;
    logic [NR-1:0]        resp_ready;
    logic [TW-1:0]        resp_tag;
    logic                 resp_err;
    logic                 busy;
    logic                 norm_hung;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ptr = 0;
    bit exp_hung = 1'b0;

    normalizer_scheduler #(
        .NUM_REQ(NR), .TAG_W(TW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .norm_sel(norm_sel), .norm_start(norm_start), .norm_done(norm_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_err(resp_err),
        .busy(busy), .norm_hung(norm_hung)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int w);
        logic [NR-1:0] one;
        one = NR'(1);
        return one << w;
    endfunction

    // Round robin: first requester at or after the pointer, wrapping around.
    function automatic int pick(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++)
            if (mask[(exp_ptr + i) % NR]) return (exp_ptr + i) % NR;
        return -1;
    endfunction

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sel"}, norm_sel, 0);
        chk({tag, "_start"}, norm_start, 0);
        chk({tag, "_rvalid"}, resp_valid, 0);
        chk({tag, "_rtag"}, resp_tag, 0);
        chk({tag, "_rerr"}, resp_err, 0);
        chk({tag, "_hung"}, norm_hung, 0);
    endtask

    // One full operation, entered and left at an IDLE cycle just after the falling edge.
    // rise_at: WAIT cycle (0-based) where done rises; >= TO means never.
    task automatic txn(input logic [NR-1:0] mask, input bit stale, input int rise_at,
                       input int delay, input bit ftag_en, input logic [TW-1:0] ftag);
        int w;
        logic [TW-1:0] tg;
        bit rose;
        for (int i = 0; i < NR; i++) req_tag[i] = ftag_en ? ftag : TW'($urandom);
        req_valid = mask;
        #1;
        w = pick(mask);
        chk("grant_ready", req_ready, oh(w));
        tg = req_tag[IW'(w)];
        @(negedge clk);
        req_valid = NR'($urandom);
        if (!stale) norm_done = 1'b0;
        #1;
        chk("issue_start", norm_start, 1);
        chk("issue_sel", norm_sel, 32'(w));
        chk("issue_ready", req_ready, 0);
        chk("issue_busy", busy, 1);
        rose = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            if (stale && k == 1) norm_done = 1'b0;
            if (k == rise_at) norm_done = 1'b1;
            #1;
            chk("wait_start", norm_start, 0);
            chk("wait_rvalid", resp_valid, 0);
            chk("wait_ready", req_ready, 0);
            if (k == rise_at) begin
                rose = 1'b1;
                break;
            end
        end
        for (int d = 0; d <= delay; d++) begin
            @(negedge clk);
            req_valid  = NR'($urandom);
            resp_ready = NR'($urandom) & ~oh(w);
            if (d == delay) resp_ready = resp_ready | oh(w);
            #1;
            chk("resp_valid", resp_valid, oh(w));
            chk("resp_tag", resp_tag, tg);
            chk("resp_err", resp_err, !rose);
            chk("resp_sel", norm_sel, 32'(w));
            chk("resp_ready_blk", req_ready, 0);
            chk("resp_start", norm_start, 0);
        end
        exp_ptr = (w + 1) % NR;
        if (!rose) exp_hung = 1'b1;
        @(negedge clk);
        resp_ready = '0;
        req_valid  = '0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_rvalid", resp_valid, 0);
        chk("post_hung", norm_hung, exp_hung);
    endtask

    initial begin
        int rise, st;
        rst = 1'b1;
        req_valid = '0;
        req_tag = '0;
        norm_done = 1'b0;
        resp_ready = '0;
        @(negedge clk);
        #1;
        chk_idle_reset("rst");
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_reset("rel");

        // single request, done 5 cycles after start
        txn(4'b0010, 1'b0, 4, 0, 1'b1, 8'hA5);
        // all requesters contending, immediate accept
        repeat (5) txn(4'b1111, 1'b0, 4, 0, 1'b0, 8'h00);
        // done left high from the previous op must not complete this one
        txn(NR'($urandom_range(1, 15)), 1'b1, 6, 0, 1'b0, 8'h00);
        // response backpressure
        txn(NR'($urandom_range(1, 15)), 1'b0, 4, 10, 1'b0, 8'h00);
        // randomized traffic
        repeat (20) begin
            st = int'($urandom_range(0, 1));
            rise = (st != 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 15));
            txn(NR'($urandom_range(1, 15)), st[0], rise, int'($urandom_range(0, 3)), 1'b0, 8'h00);
        end
        // completion on the very last allowed WAIT cycle wins over the timeout
        txn(NR'($urandom_range(1, 15)), 1'b0, TO - 1, 0, 1'b0, 8'h00);

        // reset in the middle of WAIT: request lost, pointer back to 0
        txn(4'b0100, 1'b0, 3, 0, 1'b0, 8'h00);
        req_valid = 4'b1000;
        #1;
        chk("rmw_grant", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        norm_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_reset("rmw_async");
        @(negedge clk);
        rst = 1'b0;
        norm_done = 1'b1;
        exp_ptr = 0;
        exp_hung = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rmw_no_resp", resp_valid, 0);
            chk("rmw_busy", busy, 0);
        end
        repeat (4) txn(4'b1111, 1'b0, 4, 0, 1'b0, 8'h00);

        // timeout: done never rises
        txn(NR'($urandom_range(1, 15)), 1'b0, 1000, 1, 1'b0, 8'h00);
        repeat (6) begin
            @(negedge clk);
            req_valid = NR'($urandom_range(1, 15));
            #1;
            chk("hung_ready", req_ready, 0);
            chk("hung_busy", busy, 0);
            chk("hung_start", norm_start, 0);
            chk("hung_flag", norm_hung, 1);
        end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_reset("clr");
        exp_ptr = 0;
        exp_hung = 1'b0;
        txn(4'b1111, 1'b0, 4, 0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
